// File: rtl/mux4_share_arbiter_if.sv
// Handshake bundle between the requesting pipeline units and the shared-mux arbiter.
// The master side drives requests/done; the slave (arbiter) drives grant, select and status.
interface mux4_share_arbiter_if;
  logic [3:0] req_i;
  logic       done_i;
  logic [3:0] grant_o;
  logic [1:0] sel_o;
  logic       busy_o;
  logic       timeout_o;

  modport master (
    output req_i,
    output done_i,
    input  grant_o,
    input  sel_o,
    input  busy_o,
    input  timeout_o
  );

  modport slave (
    input  req_i,
    input  done_i,
    output grant_o,
    output sel_o,
    output busy_o,
    output timeout_o
  );
endinterface

// File: rtl/mux4_share_arbiter.sv
// Round-robin arbiter owning the select of a shared 4-to-1 mux. A grant is held until done,
// requester withdrawal, or watchdog expiry; at least one idle cycle separates grants.
module mux4_share_arbiter #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  mux4_share_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam bit              WdEn    = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       grant_q, grant_d;
  logic [1:0]       sel_q, sel_d;
  logic             timeout_q, timeout_d;

  // Rotating priority scan starting at ptr_q.
  logic [1:0] pick;
  logic [1:0] cand;
  logic       found;
  always_comb begin
    pick  = ptr_q;
    cand  = '0;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cand = ptr_q + 2'(i);
      if (!found && bus.req_i[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    sel_d     = sel_q;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          state_d = StBusy;
          grant_d = 4'b0001 << pick;
          sel_d   = pick;
          cnt_d   = '0;
        end
      end
      StBusy: begin
        // done wins over withdrawal, which wins over the watchdog; sel_q is kept on release.
        if (bus.done_i || !bus.req_i[sel_q] || (WdEn && cnt_q == CntLast)) begin
          state_d   = StIdle;
          grant_d   = '0;
          ptr_d     = sel_q + 2'd1;
          timeout_d = !bus.done_i && bus.req_i[sel_q];
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q   <= StIdle;
      ptr_q     <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      sel_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.grant_o   = grant_q;
  assign bus.sel_o     = sel_q;
  assign bus.busy_o    = (state_q == StBusy);
  assign bus.timeout_o = timeout_q;

endmodule
